// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and framing constants for the UART block.
//               Optional macro UART_TX_PARITY_EN selects an 11-bit frame
//               with a parity bit; without it the frame is 10 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

`ifdef UART_TX_PARITY_EN
    localparam int   FRAME_BITS = 11;
`else
    localparam int   FRAME_BITS = 10;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled,
//               pulses bit_end on the last clock of each bit period and
//               bit_pre_end one clock earlier. Shared by TX and RX paths.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_pre  = c_cnt_w'(CLKS_PER_BIT - 2);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    assign bit_end     = enable && (r_cnt == c_last);
    assign bit_pre_end = enable && (r_cnt == c_pre);

    // Free-running bit-period counter; clear has priority so a new frame
    // always starts on a full bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Accepts a byte on a valid/ready handshake
//               and shifts out start, 8 data bits (LSB first), optional
//               parity and stop bit, each held CLKS_PER_BIT clocks.
//               Optional macro UART_TX_PARITY_EN enables the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] c_st_idle   = IDLE;
    localparam logic [2:0] c_st_start  = START;
    localparam logic [2:0] c_st_data   = DATA;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_st_parity = PARITY;
`endif
    localparam logic [2:0] c_st_stop   = STOP;
    localparam logic [2:0] c_last_idx  = 3'(DATA_BITS - 1);

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_idx;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_bit_pre_end;

`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`else
    logic                 w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    assign tx_ready  = (r_state == c_st_idle);
    assign w_accept  = tx_valid && tx_ready;
    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_accept),
        .enable      (r_state != c_st_idle),
        .bit_end     (w_bit_end),
        .bit_pre_end (w_bit_pre_end)
    );

    // Frame sequencer: the serial output is loaded one clock ahead so each
    // bit appears exactly on a bit-period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_shift  <= '0;
            r_idx    <= '0;
            r_serial <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state  <= c_st_start;
                        r_serial <= START_BIT;
                        r_busy   <= 1'b1;
                        r_shift  <= tx_data;
                        r_idx    <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^tx_data) ^ PARITY_ODD;
`endif
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_state  <= c_st_data;
                        r_serial <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        if (r_idx == c_last_idx) begin
`ifdef UART_TX_PARITY_EN
                            r_state  <= c_st_parity;
                            r_serial <= r_parity;
`else
                            r_state  <= c_st_stop;
                            r_serial <= STOP_BIT;
`endif
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_serial <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_st_parity: begin
                    if (w_bit_end) begin
                        r_state  <= c_st_stop;
                        r_serial <= STOP_BIT;
                    end
                end
`endif
                c_st_stop: begin
                    // Registered pulse lands on the final stop-bit clock.
                    if (w_bit_pre_end) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_state  <= c_st_idle;
                        r_serial <= IDLE_LEVEL;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_serial <= IDLE_LEVEL;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit path for the UART block. It accepts one parallel byte through a valid/ready handshake and builds the frame: start bit, 8 data bits, parity bit, stop bit. It then shifts the frame out LSB-first on a single serial line, holding each bit for a fixed number of clocks. It sits between the host-side byte source and the pad, and pairs with the receiver chain on the far end of the link.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200); legal range >= 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tx_data  input  8  byte to transmit; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte (high only in IDLE)
tx_serial  output  1  serial line; idle level 1
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; tx_serial = 1, tx_busy = 0, tx_done = 0, tx_ready = 1.
  - Baud counter and bit index cleared.
- tx_serial, tx_busy and tx_done are registered; tx_ready = (state == IDLE).
- Handshake: a byte is accepted when tx_valid && tx_ready at a rising edge.
  - On acceptance: latch tx_data into the shift register and latch parity.
  - Parity = ^tx_data, XOR PARITY_ODD.
  - Later changes on tx_data have no effect on the frame in flight.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake. tx_serial = 0 from the next cycle.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: bit index 0..7, LSB first, each bit held CLKS_PER_BIT cycles. -> PARITY after bit 7.
  - PARITY: parity bit held CLKS_PER_BIT cycles. -> STOP.
  - STOP: tx_serial = 1 for CLKS_PER_BIT cycles. tx_done pulses on the final cycle. -> IDLE.
- Latency: first start-bit cycle is 1 clock after the handshake. Frame length is 11*CLKS_PER_BIT cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - bit_end asserts at CLKS_PER_BIT-1 and the counter wraps to 0.
  - Counter is held at 0 in IDLE and restarts at handshake.
- Back-to-back frames:
  - tx_ready rises the cycle after the last stop cycle.
  - If tx_valid is already high, the byte is accepted that same cycle.
  - The next start bit begins one cycle later, so the gap is exactly 1 extra idle-high clock.
- tx_valid while busy: ignored, no state change; the byte stays pending at the source.
- Reset mid-frame: tx_serial returns to 1 immediately (async). The frame is lost and no tx_done is issued.

Optional Feature:
UART_TX_PARITY_EN
- Defined: 11-bit frame with a PARITY state, as above.
- Undefined:
  - PARITY state and parity logic are compiled out; DATA -> STOP directly.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LEVEL = 1'b1, DATA_BITS = 8;
  - FRAME_BITS (11, or 10 without parity).
- Sub-module uart_baud_gen: a parameterised CLKS_PER_BIT counter.
  - Inputs: clk, rst, clear, enable. Output: bit_end pulse.
  - Kept separate so the receiver can reuse it.

Test Plan:
1. CLKS_PER_BIT=4, even parity, send 0xA5.
   - tx_serial = 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 clocks.
   - tx_done pulses at cycle 44 after the handshake; tx_ready is 1 at cycle 45.
2. Send 0x07 with PARITY_ODD=0 -> parity bit 1. Repeat with PARITY_ODD=1 -> parity bit 0. Data bits 1,1,1,0,0,0,0,0.
3. Hold tx_valid high with 0x00 then 0xFF.
   - Second handshake occurs the cycle tx_ready rises.
   - Exactly 1 idle-high clock separates the stop bit from the next start bit.
   - Both frames are correct.
4. Mid-frame (cycle 12), toggle tx_data to 0x3C and pulse tx_valid.
   - Frame still carries 0xA5; tx_ready stays 0; no second frame starts.
5. Assert rst at cycle 20 of a frame.
   - tx_serial = 1 and tx_busy = 0 in the same cycle; no tx_done.
   - After release, 0x5A transmits cleanly.
6. UART_TX_PARITY_EN undefined, send 0x81.
   - 10-bit frame: 0,1,0,0,0,0,0,0,1,1.
   - tx_done at cycle 40.
